// File: rtl/pipelined_array_mult.sv
// Pipelined signed/unsigned array multiplier. Partial-product rows are spread over
// STAGES registered stages in carry-save form; the last stage resolves carries.
module pipelined_array_mult #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               out_signed,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW  = 2 * WIDTH;
  localparam int RPS = (WIDTH + STAGES - 1) / STAGES;
  // Baugh-Wooley correction constant: ones at bit WIDTH and bit 2*WIDTH-1.
  localparam logic [PW-1:0] BW_CONST = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_signed;
  logic [PW-1:0]     r_sum   [STAGES];
  logic [PW-1:0]     r_carry [STAGES];
  logic [WIDTH-1:0]  r_a     [STAGES];
  logic [WIDTH-1:0]  r_b     [STAGES];
  logic [TAG_W-1:0]  r_tag   [STAGES];

  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_upValid;
  logic [STAGES-1:0] w_upSigned;
  logic [PW-1:0]     w_upSum     [STAGES];
  logic [PW-1:0]     w_upCarry   [STAGES];
  logic [PW-1:0]     w_nextSum   [STAGES];
  logic [PW-1:0]     w_nextCarry [STAGES];
  logic [WIDTH-1:0]  w_upA       [STAGES];
  logic [WIDTH-1:0]  w_upB       [STAGES];
  logic [TAG_W-1:0]  w_upTag     [STAGES];

  // A stage loads when empty or when its contents move on (bubble collapse).
  always_comb begin
    w_load = '0;
    w_load[STAGES-1] = !r_valid[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_load[k] = !r_valid[k] || w_load[k+1];
    end
  end

  assign in_ready = w_load[0];

  always_comb begin
    w_upValid[0]  = in_valid;
    w_upSigned[0] = in_signed;
    w_upSum[0]    = in_signed ? BW_CONST : '0;
    w_upCarry[0]  = '0;
    w_upA[0]      = A;
    w_upB[0]      = B;
    w_upTag[0]    = in_tag;
    for (int k = 1; k < STAGES; k++) begin
      w_upValid[k]  = r_valid[k-1];
      w_upSigned[k] = r_signed[k-1];
      w_upSum[k]    = r_sum[k-1];
      w_upCarry[k]  = r_carry[k-1];
      w_upA[k]      = r_a[k-1];
      w_upB[k]      = r_b[k-1];
      w_upTag[k]    = r_tag[k-1];
    end
  end

  // Each row is folded into the sum/carry pair with one row of full adders.
  always_comb begin
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    logic [PW-1:0] ns;
    logic [PW-1:0] pp;
    logic          bitVal;
    int            row;
    s      = '0;
    c      = '0;
    ns     = '0;
    pp     = '0;
    bitVal = 1'b0;
    row    = 0;
    for (int k = 0; k < STAGES; k++) begin
      s = w_upSum[k];
      c = w_upCarry[k];
      for (int r = 0; r < RPS; r++) begin
        row = k * RPS + r;
        pp  = '0;
        if (row < WIDTH) begin
          for (int j = 0; j < WIDTH; j++) begin
            bitVal = w_upA[k][j] & w_upB[k][row];
            if (w_upSigned[k] && ((row == WIDTH - 1) != (j == WIDTH - 1))) begin
              bitVal = ~bitVal;
            end
            pp[row+j] = bitVal;
          end
          ns = s ^ c ^ pp;
          c  = ((s & c) | (s & pp) | (c & pp)) << 1;
          s  = ns;
        end
      end
      if (k == STAGES - 1) begin
        s = s + c;
        c = '0;
      end
      w_nextSum[k]   = s;
      w_nextCarry[k] = c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= '0;
      r_signed <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_sum[k]   <= '0;
        r_carry[k] <= '0;
        r_a[k]     <= '0;
        r_b[k]     <= '0;
        r_tag[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= w_upValid[k];
          if (w_upValid[k]) begin
            r_signed[k] <= w_upSigned[k];
            r_sum[k]    <= w_nextSum[k];
            r_carry[k]  <= w_nextCarry[k];
            r_a[k]      <= w_upA[k];
            r_b[k]      <= w_upB[k];
            r_tag[k]    <= w_upTag[k];
          end
        end
      end
    end
  end

  assign out_valid  = r_valid[STAGES-1];
  assign out        = r_sum[STAGES-1];
  assign out_signed = r_signed[STAGES-1];
  assign out_tag    = r_tag[STAGES-1];

endmodule

// File: tb/tb_pipelined_array_mult.sv
// Directed bench for pipelined_array_mult: an 8x8/4-stage instance for handshake,
// latency, backpressure and reset, plus a 64x64/8-stage instance for wide corners.
module tb_pipelined_array_mult;

  logic clk;
  logic rst;

  logic        inValid8, inReady8, inSigned8, outValid8, outReady8, outSigned8;
  logic [7:0]  a8, b8;
  logic [3:0]  inTag8, outTag8;
  logic [15:0] out8;

  logic         inValid64, inReady64, inSigned64, outValid64, outReady64, outSigned64;
  logic [63:0]  a64, b64;
  logic [3:0]   inTag64, outTag64;
  logic [127:0] out64;

  int checkCount = 0;
  int passCount  = 0;

  pipelined_array_mult #(.WIDTH(8), .STAGES(4), .TAG_W(4)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(inValid8), .in_ready(inReady8), .in_signed(inSigned8),
    .A(a8), .B(b8), .in_tag(inTag8),
    .out_valid(outValid8), .out_ready(outReady8), .out(out8),
    .out_signed(outSigned8), .out_tag(outTag8)
  );

  pipelined_array_mult #(.WIDTH(64), .STAGES(8), .TAG_W(4)) u64 (
    .clk(clk), .rst(rst),
    .in_valid(inValid64), .in_ready(inReady64), .in_signed(inSigned64),
    .A(a64), .B(b64), .in_tag(inTag64),
    .out_valid(outValid64), .out_ready(outReady64), .out(out64),
    .out_signed(outSigned64), .out_tag(outTag64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // One item through the empty 8-bit pipe; latency counted in cycles after the accept edge.
  task automatic applyStimulus8(input string name, input logic [7:0] a, input logic [7:0] b,
                                input logic s, input logic [3:0] tag, input logic [15:0] expOut);
    int lat;
    @(negedge clk);
    checkOutput({name, "_rdy"}, 128'(inReady8), 128'(1));
    a8 = a; b8 = b; inSigned8 = s; inTag8 = tag; inValid8 = 1'b1; outReady8 = 1'b1;
    @(negedge clk);
    inValid8 = 1'b0;
    lat = 1;
    while (!outValid8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({name, "_lat"}, 128'(lat), 128'(4));
    checkOutput({name, "_out"}, 128'(out8), 128'(expOut));
    checkOutput({name, "_sgn"}, 128'(outSigned8), 128'(s));
    checkOutput({name, "_tag"}, 128'(outTag8), 128'(tag));
  endtask

  task automatic applyStimulus64(input string name, input logic [63:0] a, input logic [63:0] b,
                                 input logic s, input logic [3:0] tag, input logic [127:0] expOut);
    int lat;
    @(negedge clk);
    a64 = a; b64 = b; inSigned64 = s; inTag64 = tag; inValid64 = 1'b1;
    @(negedge clk);
    inValid64 = 1'b0;
    lat = 1;
    while (!outValid64 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({name, "_lat"}, 128'(lat), 128'(8));
    checkOutput({name, "_out"}, out64, expOut);
    checkOutput({name, "_tag"}, 128'(outTag64), 128'(tag));
  endtask

  initial begin
    rst = 1'b1;
    inValid8 = 1'b0; inSigned8 = 1'b0; a8 = '0; b8 = '0; inTag8 = '0; outReady8 = 1'b1;
    inValid64 = 1'b0; inSigned64 = 1'b0; a64 = '0; b64 = '0; inTag64 = '0; outReady64 = 1'b1;

    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_vld", 128'(outValid8), 128'(0));
    checkOutput("rst_out", 128'(out8), 128'(0));
    checkOutput("rst_tag", 128'(outTag8), 128'(0));
    checkOutput("rst_sgn", 128'(outSigned8), 128'(0));
    checkOutput("rst_vld64", 128'(outValid64), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_rdy", 128'(inReady8), 128'(1));

    applyStimulus8("t1_ffxff_u", 8'hFF, 8'hFF, 1'b0, 4'h3, 16'hFE01);
    applyStimulus8("t2_80x80_s", 8'h80, 8'h80, 1'b1, 4'h4, 16'h4000);
    applyStimulus8("t2_ffx02_s", 8'hFF, 8'h02, 1'b1, 4'h5, 16'hFFFE);
    applyStimulus8("t2_ffx02_u", 8'hFF, 8'h02, 1'b0, 4'h6, 16'h01FE);
    applyStimulus8("t2_7fx80_s", 8'h7F, 8'h80, 1'b1, 4'h7, 16'hC080);
    applyStimulus8("t2_ffxff_s", 8'hFF, 8'hFF, 1'b1, 4'h8, 16'h0001);
    applyStimulus8("t2_00x5a_u", 8'h00, 8'h5A, 1'b0, 4'h9, 16'h0000);

    // Back-to-back stream: 16 items, tags 0..15, product (i+1)*0xC3.
    outReady8 = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          @(negedge clk);
          checkOutput("t3_rdy", 128'(inReady8), 128'(1));
          a8 = 8'(i + 1); b8 = 8'hC3; inSigned8 = 1'b0; inTag8 = 4'(i); inValid8 = 1'b1;
        end
        @(negedge clk);
        inValid8 = 1'b0;
      end
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!outValid8 && w < 20) begin
          @(negedge clk);
          w++;
        end
        checkOutput("t3_first_lat", 128'(w), 128'(4));
        for (int i = 0; i < 16; i++) begin
          if (i > 0) @(negedge clk);
          checkOutput("t3_vld", 128'(outValid8), 128'(1));
          checkOutput("t3_tag", 128'(outTag8), 128'(i));
          checkOutput("t3_out", 128'(out8), 128'((i + 1) * 195));
        end
      end
    join
    @(negedge clk);
    checkOutput("t3_drained", 128'(outValid8), 128'(0));

    // Backpressure: fill with 4 items, hold, then drain while two more enter.
    outReady8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t4_rdy_fill", 128'(inReady8), 128'(1));
      a8 = 8'(16 + i); b8 = 8'h0B; inSigned8 = 1'b0; inTag8 = 4'(8 + i); inValid8 = 1'b1;
    end
    @(negedge clk);
    a8 = 8'd20; inTag8 = 4'd12;
    for (int h = 0; h < 3; h++) begin
      checkOutput("t4_rdy_full", 128'(inReady8), 128'(0));
      checkOutput("t4_hold_vld", 128'(outValid8), 128'(1));
      checkOutput("t4_hold_out", 128'(out8), 128'(176));
      checkOutput("t4_hold_tag", 128'(outTag8), 128'(8));
      @(negedge clk);
    end
    outReady8 = 1'b1;
    #1;
    for (int j = 0; j < 6; j++) begin
      checkOutput("t4_drain_vld", 128'(outValid8), 128'(1));
      checkOutput("t4_drain_tag", 128'(outTag8), 128'(8 + j));
      checkOutput("t4_drain_out", 128'(out8), 128'((16 + j) * 11));
      if (j == 0) checkOutput("t4_rdy_swap", 128'(inReady8), 128'(1));
      if (j == 1) begin
        a8 = 8'd21; inTag8 = 4'd13;
      end
      if (j == 2) inValid8 = 1'b0;
      @(negedge clk);
    end
    checkOutput("t4_empty", 128'(outValid8), 128'(0));

    // Reset with three items in flight; the first one is already at the output.
    outReady8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a8 = 8'(i + 2); b8 = 8'h21; inSigned8 = 1'b0; inTag8 = 4'(i + 1); inValid8 = 1'b1;
    end
    @(negedge clk);
    inValid8 = 1'b0;
    @(negedge clk);
    checkOutput("t5_pre_vld", 128'(outValid8), 128'(1));
    checkOutput("t5_pre_out", 128'(out8), 128'(16'h0042));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5_async_vld", 128'(outValid8), 128'(0));
    checkOutput("t5_async_out", 128'(out8), 128'(0));
    checkOutput("t5_async_tag", 128'(outTag8), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    outReady8 = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (outValid8) seen++;
      end
      checkOutput("t5_no_stale", 128'(seen), 128'(0));
    end
    applyStimulus8("t5_recover", 8'h0F, 8'h0F, 1'b0, 4'hA, 16'h00E1);

    applyStimulus64("w_max_u", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'h1,
                    128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    applyStimulus64("w_min_s", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 4'h2,
                    128'h4000_0000_0000_0000_0000_0000_0000_0000);
    applyStimulus64("w_m1x2_s", 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1'b1, 4'h3,
                    128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);
    applyStimulus64("w_maxmin_s", 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 4'h4,
                    128'hC000_0000_0000_0000_8000_0000_0000_0000);
    applyStimulus64("w_2p32_u", 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 1'b0, 4'h5,
                    128'h0000_0000_0000_0001_0000_0000_0000_0000);
    applyStimulus64("w_shift_u", 64'h1234_5678_9ABC_DEF0, 64'h10, 1'b0, 4'h6,
                    128'h0000_0000_0000_0001_2345_6789_ABCD_EF00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
